noc_vortex_ctrl_bridge: RTL and testbench

// - NoC-side request port to AXI4-Lite master bridge for the Vortex control register file (chipset, vortex_bridge).
// - Converts byte/half/word/dword accesses (buf_data_sz encoding) into one or two AXI4-Lite beats.
// - Returns right-aligned read data plus an error flag. Single outstanding transaction.

---
 rtl/noc_vortex_ctrl_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_noc_vortex_ctrl_bridge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vortex_ctrl_bridge.sv
// noc_vortex_ctrl_bridge
//   Bridges a single-outstanding NoC request port onto an AXI4-Lite master that reaches the
//   Vortex control register file. Byte/half/word/dword accesses are lane-aligned onto the AXI
//   bus. A dword access on a 32-bit bus is split into two beats. Read data is returned
//   right-aligned and zero-extended, together with an error flag.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_*                 request: valid/ready, byte address, right-aligned write data,
//                         write enable, size (0=1B, 1=2B, 2=4B, 3=8B)
//   rsp_*                 response: valid/ready, right-aligned read data (0 for writes),
//                         error (misaligned, non-OKAY AXI response, or timeout)
//   m_axi_ctrl_*          AXI4-Lite master (AW, W, B, AR, R channels)
//
// Configuration macro
//   VORTEX_CTRL_TIMEOUT_EN  bounds the B/R wait to TIMEOUT_CYCLES. It also keeps bready/rready
//                           high in idle, so that stale responses are drained and dropped.
module noc_vortex_ctrl_bridge #(
    parameter int unsigned VORTEX_AXI_CTRL_ADDR_WIDTH = 8,
    parameter int unsigned VORTEX_AXI_CTRL_DATA_WIDTH = 32,
    parameter int unsigned NOC_DATA_WIDTH             = 64,
    parameter int unsigned TIMEOUT_CYCLES             = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req_valid_i,
    output logic                                    req_ready_o,
    input  logic [31:0]                             req_addr_i,
    input  logic [NOC_DATA_WIDTH-1:0]               req_data_i,
    input  logic                                    req_we_i,
    input  logic [1:0]                              req_size_i,
    output logic                                    rsp_valid_o,
    input  logic                                    rsp_ready_i,
    output logic [NOC_DATA_WIDTH-1:0]               rsp_data_o,
    output logic                                    rsp_err_o,
    output logic                                    m_axi_ctrl_awvalid,
    input  logic                                    m_axi_ctrl_awready,
    output logic [VORTEX_AXI_CTRL_ADDR_WIDTH-1:0]   m_axi_ctrl_awaddr,
    output logic                                    m_axi_ctrl_wvalid,
    input  logic                                    m_axi_ctrl_wready,
    output logic [VORTEX_AXI_CTRL_DATA_WIDTH-1:0]   m_axi_ctrl_wdata,
    output logic [VORTEX_AXI_CTRL_DATA_WIDTH/8-1:0] m_axi_ctrl_wstrb,
    input  logic                                    m_axi_ctrl_bvalid,
    output logic                                    m_axi_ctrl_bready,
    input  logic [1:0]                              m_axi_ctrl_bresp,
    output logic                                    m_axi_ctrl_arvalid,
    input  logic                                    m_axi_ctrl_arready,
    output logic [VORTEX_AXI_CTRL_ADDR_WIDTH-1:0]   m_axi_ctrl_araddr,
    input  logic                                    m_axi_ctrl_rvalid,
    output logic                                    m_axi_ctrl_rready,
    input  logic [VORTEX_AXI_CTRL_DATA_WIDTH-1:0]   m_axi_ctrl_rdata,
    input  logic [1:0]                              m_axi_ctrl_rresp
);
    localparam int unsigned AW        = VORTEX_AXI_CTRL_ADDR_WIDTH;
    localparam int unsigned DW        = VORTEX_AXI_CTRL_DATA_WIDTH;
    localparam int unsigned LaneBytes = DW / 8;
    localparam int unsigned OffW      = $clog2(LaneBytes);

    typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata, StResp} state_e;

    state_e          r_state, w_state_next;
    logic            r_two, r_beat, r_err;
    logic [OffW-1:0] r_off;
    logic [1:0]      r_size;
    logic [63:0]     r_data, r_rdata;
    logic [AW-1:0]   r_addr;
    logic            r_awvalid, r_wvalid, r_arvalid;

    logic        w_req_fire, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
    logic        w_misalign, w_more, w_tmo_hit;
    logic [3:0]  w_size_lsb;
    logic [2:0]  w_align_mask;
    logic [63:0] w_beat_data, w_wdata_wide, w_rdata_shift, w_size_mask;
    logic [7:0]  w_byte_mask, w_strb_wide;
    logic        w_unused;

    assign w_unused = ^req_addr_i[31:AW];

    assign w_req_fire = req_valid_i && (r_state == StIdle);
    assign w_aw_fire  = r_awvalid && m_axi_ctrl_awready;
    assign w_w_fire   = r_wvalid && m_axi_ctrl_wready;
    assign w_b_fire   = (r_state == StWresp) && m_axi_ctrl_bvalid;
    assign w_ar_fire  = r_arvalid && m_axi_ctrl_arready;
    assign w_r_fire   = (r_state == StRdata) && m_axi_ctrl_rvalid;
    assign w_more     = r_two && !r_beat;

    // (1 << size) - 1 in three bits; size 3 wraps 0 - 1 to 3'b111.
    assign w_size_lsb   = 4'd1 << req_size_i;
    assign w_align_mask = w_size_lsb[2:0] - 3'd1;
    assign w_misalign   = |(req_addr_i[2:0] & w_align_mask);

    always_comb begin
        w_byte_mask = 8'h01;
        w_size_mask = 64'hFF;
        case (r_size)
            2'd0: begin w_byte_mask = 8'h01; w_size_mask = 64'h0000_0000_0000_00FF; end
            2'd1: begin w_byte_mask = 8'h03; w_size_mask = 64'h0000_0000_0000_FFFF; end
            2'd2: begin w_byte_mask = 8'h0F; w_size_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin w_byte_mask = 8'hFF; w_size_mask = '1; end
        endcase
    end

    // Split dwords feed one 32-bit half per beat; the byte mask truncates to 4'hF on a 32-bit bus.
    assign w_beat_data   = r_two ? {32'd0, (r_beat ? r_data[63:32] : r_data[31:0])} : r_data;
    assign w_wdata_wide  = w_beat_data << {r_off, 3'b000};
    assign w_strb_wide   = w_byte_mask << r_off;
    assign w_rdata_shift = 64'(m_axi_ctrl_rdata) >> {r_off, 3'b000};

`ifdef VORTEX_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] r_tmo;
    logic            w_waiting;

    assign w_waiting = ((r_state == StWresp) && !w_b_fire) || ((r_state == StRdata) && !w_r_fire);
    assign w_tmo_hit = w_waiting && (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)            r_tmo <= '0;
        else if (w_waiting) r_tmo <= r_tmo + TmoW'(1);
        else                r_tmo <= '0;
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_req_fire) begin
                    if (w_misalign)    w_state_next = StResp;
                    else if (req_we_i) w_state_next = StWaddr;
                    else               w_state_next = StRaddr;
                end
            end
            StWaddr: begin
                if ((!r_awvalid || m_axi_ctrl_awready) && (!r_wvalid || m_axi_ctrl_wready)) begin
                    w_state_next = StWresp;
                end
            end
            StWresp: begin
                if (w_b_fire)       w_state_next = w_more ? StWaddr : StResp;
                else if (w_tmo_hit) w_state_next = StResp;
            end
            StRaddr: if (w_ar_fire) w_state_next = StRdata;
            StRdata: begin
                if (w_r_fire)       w_state_next = w_more ? StRaddr : StResp;
                else if (w_tmo_hit) w_state_next = StResp;
            end
            StResp:  if (rsp_ready_i) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_two     <= 1'b0;
            r_beat    <= 1'b0;
            r_err     <= 1'b0;
            r_off     <= '0;
            r_size    <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (w_req_fire) begin
                        r_two     <= (req_size_i == 2'd3) && (DW == 32);
                        r_beat    <= 1'b0;
                        r_err     <= w_misalign;
                        r_off     <= req_addr_i[OffW-1:0];
                        r_size    <= req_size_i;
                        r_data    <= req_data_i;
                        r_rdata   <= '0;
                        r_addr    <= req_addr_i[AW-1:0] & ~AW'(LaneBytes - 1);
                        r_awvalid <= req_we_i && !w_misalign;
                        r_wvalid  <= req_we_i && !w_misalign;
                        r_arvalid <= !req_we_i && !w_misalign;
                    end
                end
                StWaddr: begin
                    if (w_aw_fire) r_awvalid <= 1'b0;
                    if (w_w_fire)  r_wvalid  <= 1'b0;
                end
                StWresp: begin
                    if (w_b_fire) begin
                        r_err <= r_err | (|m_axi_ctrl_bresp);
                        if (w_more) begin
                            r_beat    <= 1'b1;
                            r_addr    <= r_addr + AW'(4);
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                StRaddr: if (w_ar_fire) r_arvalid <= 1'b0;
                StRdata: begin
                    if (w_r_fire) begin
                        r_err <= r_err | (|m_axi_ctrl_rresp);
                        if (!r_two)      r_rdata        <= w_rdata_shift & w_size_mask;
                        else if (r_beat) r_rdata[63:32] <= m_axi_ctrl_rdata[31:0];
                        else             r_rdata[31:0]  <= m_axi_ctrl_rdata[31:0];
                        if (w_more) begin
                            r_beat    <= 1'b1;
                            r_addr    <= r_addr + AW'(4);
                            r_arvalid <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o        = (r_state == StIdle);
    assign rsp_valid_o        = (r_state == StResp);
    assign rsp_data_o         = rsp_valid_o ? r_rdata : '0;
    assign rsp_err_o          = rsp_valid_o && r_err;
    assign m_axi_ctrl_awvalid = r_awvalid;
    assign m_axi_ctrl_wvalid  = r_wvalid;
    assign m_axi_ctrl_arvalid = r_arvalid;
    assign m_axi_ctrl_awaddr  = r_addr;
    assign m_axi_ctrl_araddr  = r_addr;
    assign m_axi_ctrl_wdata   = w_wdata_wide[DW-1:0];
    assign m_axi_ctrl_wstrb   = w_strb_wide[LaneBytes-1:0];
`ifdef VORTEX_CTRL_TIMEOUT_EN
    assign m_axi_ctrl_bready  = (r_state == StWresp) || (r_state == StIdle);
    assign m_axi_ctrl_rready  = (r_state == StRdata) || (r_state == StIdle);
`else
    assign m_axi_ctrl_bready  = (r_state == StWresp);
    assign m_axi_ctrl_rready  = (r_state == StRdata);
`endif

endmodule

// File: tb/tb_noc_vortex_ctrl_bridge.sv
// tb_noc_vortex_ctrl_bridge
//   Directed bench for noc_vortex_ctrl_bridge (32-bit AXI data, 8-bit AXI address).
//   Inputs are driven and outputs sampled at the falling clock edge. The AXI slave is
//   scripted cycle by cycle inside each scenario task. Define VORTEX_CTRL_TIMEOUT_EN to
//   add the timeout scenario (TIMEOUT_CYCLES = 16).
module tb_noc_vortex_ctrl_bridge;
`ifdef VORTEX_CTRL_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_data;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    noc_vortex_ctrl_bridge #(
        .VORTEX_AXI_CTRL_ADDR_WIDTH(8),
        .VORTEX_AXI_CTRL_DATA_WIDTH(32),
        .NOC_DATA_WIDTH(64),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_we_i(req_we), .req_size_i(req_size),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err),
        .m_axi_ctrl_awvalid(awvalid), .m_axi_ctrl_awready(awready), .m_axi_ctrl_awaddr(awaddr),
        .m_axi_ctrl_wvalid(wvalid), .m_axi_ctrl_wready(wready), .m_axi_ctrl_wdata(wdata),
        .m_axi_ctrl_wstrb(wstrb),
        .m_axi_ctrl_bvalid(bvalid), .m_axi_ctrl_bready(bready), .m_axi_ctrl_bresp(bresp),
        .m_axi_ctrl_arvalid(arvalid), .m_axi_ctrl_arready(arready), .m_axi_ctrl_araddr(araddr),
        .m_axi_ctrl_rvalid(rvalid), .m_axi_ctrl_rready(rready), .m_axi_ctrl_rdata(rdata),
        .m_axi_ctrl_rresp(rresp)
    );

    // Presents one request for one cycle; returns at the falling edge of the cycle after accept.
    task automatic issue(input logic [31:0] a, input logic [63:0] d, input logic we,
                         input logic [1:0] sz);
        req_valid = 1'b1; req_addr = a; req_data = d; req_we = we; req_size = sz;
        @(negedge clk);
        req_valid = 1'b0; req_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin n_bad++; $display("FAIL rst_axi_valids: got %b want 000", {awvalid, wvalid, arvalid}); end
        n_cmp++; if ({bready, rready} !== {TmoEn, TmoEn}) begin n_bad++; $display("FAIL rst_b_r_ready: got %b want %b", {bready, rready}, {TmoEn, TmoEn}); end
        n_cmp++; if ({rsp_err, rsp_data} !== 65'd0) begin n_bad++; $display("FAIL rst_rsp_err_data: got %b/%h want 0/0", rsp_err, rsp_data); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_word();
        issue(32'h14, 64'hDEAD_BEEF, 1'b1, 2'd2);
        n_cmp++; if ({awvalid, wvalid, arvalid} !== 3'b110) begin n_bad++; $display("FAIL ww_valids: got %b want 110", {awvalid, wvalid, arvalid}); end
        n_cmp++; if (awaddr !== 8'h14) begin n_bad++; $display("FAIL ww_awaddr: got %h want 14", awaddr); end
        n_cmp++; if (wstrb !== 4'hF) begin n_bad++; $display("FAIL ww_wstrb: got %h want f", wstrb); end
        n_cmp++; if (wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ww_wdata: got %h want deadbeef", wdata); end
        @(negedge clk);
        n_cmp++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_bad++; $display("FAIL ww_wresp: got %b want 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_bad++; $display("FAIL ww_rsp_latency: got %b want 10", {rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_data !== 64'd0) begin n_bad++; $display("FAIL ww_rsp_data: got %h want 0", rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL ww_back_idle: got %b want 10", {req_ready, rsp_valid}); end
    endtask

    task automatic test_read_lanes();
        logic [31:0] t_addr [3];
        logic [1:0]  t_size [3];
        logic [31:0] t_rd   [3];
        logic [7:0]  t_ar   [3];
        logic [63:0] t_exp  [3];
        t_addr = '{32'h13, 32'h06, 32'h28};
        t_size = '{2'd0, 2'd1, 2'd2};
        t_rd   = '{32'hAABB_CCDD, 32'h89AB_CDEF, 32'h1357_9BDF};
        t_ar   = '{8'h10, 8'h04, 8'h28};
        t_exp  = '{64'hAA, 64'h89AB, 64'h1357_9BDF};
        for (int i = 0; i < 3; i++) begin
            issue(t_addr[i], 64'd0, 1'b0, t_size[i]);
            n_cmp++; if ({arvalid, awvalid} !== 2'b10) begin n_bad++; $display("FAIL rd%0d_arvalid: got %b want 10", i, {arvalid, awvalid}); end
            n_cmp++; if (araddr !== t_ar[i]) begin n_bad++; $display("FAIL rd%0d_araddr: got %h want %h", i, araddr, t_ar[i]); end
            @(negedge clk);
            n_cmp++; if ({rready, arvalid} !== 2'b10) begin n_bad++; $display("FAIL rd%0d_rready: got %b want 10", i, {rready, arvalid}); end
            rvalid = 1'b1; rdata = t_rd[i]; rresp = 2'b00;
            @(negedge clk);
            rvalid = 1'b0;
            n_cmp++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_bad++; $display("FAIL rd%0d_rsp: got %b want 10", i, {rsp_valid, rsp_err}); end
            n_cmp++; if (rsp_data !== t_exp[i]) begin n_bad++; $display("FAIL rd%0d_data: got %h want %h", i, rsp_data, t_exp[i]); end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_write_dword();
        issue(32'h08, 64'h1122_3344_5566_7788, 1'b1, 2'd3);
        n_cmp++; if ({awaddr, wdata, wstrb} !== {8'h08, 32'h5566_7788, 4'hF}) begin n_bad++; $display("FAIL wd_beat0: got %h/%h/%h want 08/55667788/f", awaddr, wdata, wstrb); end
        @(negedge clk);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        n_cmp++; if ({awvalid, wvalid, rsp_valid} !== 3'b110) begin n_bad++; $display("FAIL wd_beat1_valid: got %b want 110", {awvalid, wvalid, rsp_valid}); end
        n_cmp++; if ({awaddr, wdata, wstrb} !== {8'h0C, 32'h1122_3344, 4'hF}) begin n_bad++; $display("FAIL wd_beat1: got %h/%h/%h want 0c/11223344/f", awaddr, wdata, wstrb); end
        @(negedge clk);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 64'd0}) begin n_bad++; $display("FAIL wd_rsp: got %b/%b/%h want 1/0/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_dword_sticky_err();
        issue(32'h30, 64'd0, 1'b0, 2'd3);
        n_cmp++; if ({arvalid, araddr} !== {1'b1, 8'h30}) begin n_bad++; $display("FAIL rdd_beat0: got %b/%h want 1/30", arvalid, araddr); end
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
        @(negedge clk);
        rvalid = 1'b0; rresp = 2'b00;
        n_cmp++; if ({arvalid, araddr} !== {1'b1, 8'h34}) begin n_bad++; $display("FAIL rdd_beat1: got %b/%h want 1/34", arvalid, araddr); end
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h0123_4567;
        @(negedge clk);
        rvalid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_bad++; $display("FAIL rdd_sticky_err: got %b want 11", {rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_data !== 64'h0123_4567_CAFE_F00D) begin n_bad++; $display("FAIL rdd_data: got %h want 01234567cafef00d", rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        issue(32'h03, 64'd0, 1'b0, 2'd1);
        n_cmp++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin n_bad++; $display("FAIL mis_no_axi: got %b want 000", {awvalid, wvalid, arvalid}); end
        n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 64'd0}) begin n_bad++; $display("FAIL mis_rsp: got %b/%b/%h want 1/1/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(32'h16, 64'h1, 1'b1, 2'd2);
        n_cmp++; if ({awvalid, wvalid, rsp_valid, rsp_err} !== 4'b0011) begin n_bad++; $display("FAIL mis_wr: got %b want 0011", {awvalid, wvalid, rsp_valid, rsp_err}); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mis_idle: got %b want 1", req_ready); end
    endtask

    task automatic test_stall_bresp();
        awready = 1'b0; wready = 1'b0;
        issue(32'h21, 64'hA5, 1'b1, 2'd0);
        n_cmp++; if ({awaddr, wdata, wstrb} !== {8'h20, 32'h0000_A500, 4'h2}) begin n_bad++; $display("FAIL st_beat: got %h/%h/%h want 20/0000a500/2", awaddr, wdata, wstrb); end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        n_cmp++; if ({awvalid, wvalid} !== 2'b01) begin n_bad++; $display("FAIL st_aw_done: got %b want 01", {awvalid, wvalid}); end
        @(negedge clk);
        n_cmp++; if ({wvalid, bready} !== 2'b10) begin n_bad++; $display("FAIL st_w_held: got %b want 10", {wvalid, bready}); end
        @(negedge clk);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        n_cmp++; if ({wvalid, bready} !== 2'b01) begin n_bad++; $display("FAIL st_w_done: got %b want 01", {wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 64'd0}) begin n_bad++; $display("FAIL st_rsp_hold%0d: got %b/%b/%h want 1/1/0", i, rsp_valid, rsp_err, rsp_data); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL st_idle: got %b want 10", {req_ready, rsp_valid}); end
        awready = 1'b1; wready = 1'b1;
    endtask

    task automatic test_reset_mid();
        awready = 1'b0; wready = 1'b0;
        issue(32'h40, 64'h1, 1'b1, 2'd2);
        n_cmp++; if ({awvalid, wvalid} !== 2'b11) begin n_bad++; $display("FAIL rm_started: got %b want 11", {awvalid, wvalid}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({awvalid, wvalid, req_ready, rsp_valid} !== 4'b0010) begin n_bad++; $display("FAIL rm_dropped: got %b want 0010", {awvalid, wvalid, req_ready, rsp_valid}); end
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({awvalid, rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL rm_no_rsp: got %b want 00", {awvalid, rsp_valid}); end
    endtask

`ifdef VORTEX_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        issue(32'h40, 64'd0, 1'b0, 2'd2);
        @(negedge clk);
        n_cmp++; if ({rready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL to_rdata: got %b want 10", {rready, rsp_valid}); end
        repeat (15) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", rsp_valid); end
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 64'd0}) begin n_bad++; $display("FAIL to_rsp: got %b/%b/%h want 1/1/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if ({req_ready, rready, bready} !== 3'b111) begin n_bad++; $display("FAIL to_idle_drain: got %b want 111", {req_ready, rready, bready}); end
        rvalid = 1'b1; rdata = 32'hFFFF; rresp = 2'b10;
        @(negedge clk);
        rvalid = 1'b0; rresp = 2'b00;
        n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL to_stale_absorbed: got %b want 10", {req_ready, rsp_valid}); end
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_we = 1'b0; req_size = '0;
        rsp_ready = 1'b0; awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bresp = '0; rvalid = 1'b0; rdata = '0; rresp = '0;
        test_reset();
        test_write_word();
        test_read_lanes();
        test_write_dword();
        test_read_dword_sticky_err();
        test_misaligned();
        test_stall_bresp();
        test_reset_mid();
`ifdef VORTEX_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
